// File: rtl/lift_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lift_pkg
//  Description : Shared types and helpers for the multi-car lift controller.
//                Door/direction/car-state encodings and bitmap scan helpers.
//  Revision    : 1.0  initial release
// ============================================================================
package lift_pkg;

    // Largest supported building; bitmap helpers work on this fixed width.
    localparam int c_MAX_FLOORS = 64;

    typedef enum logic [1:0] {
        DOOR_CLOSED = 2'b00,
        DOOR_OPEN   = 2'b01,
        DOOR_HELD   = 2'b10
    } door_t;

    typedef enum logic [1:0] {
        DIR_IDLE = 2'b00,
        DIR_UP   = 2'b01,
        DIR_DOWN = 2'b10
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MOVING = 2'd1,
        ST_DOOR   = 2'd2,
        ST_ESTOP  = 2'd3
    } car_state_t;

    // True if any bit strictly above 'floor' is set.
    function automatic logic any_above(input logic [c_MAX_FLOORS-1:0] bitmap,
                                       input int floor);
        logic r;
        r = 1'b0;
        for (int i = 0; i < c_MAX_FLOORS; i++) begin
            if (i > floor && bitmap[i]) r = 1'b1;
        end
        return r;
    endfunction

    // True if any bit strictly below 'floor' is set.
    function automatic logic any_below(input logic [c_MAX_FLOORS-1:0] bitmap,
                                       input int floor);
        logic r;
        r = 1'b0;
        for (int i = 0; i < c_MAX_FLOORS; i++) begin
            if (i < floor && bitmap[i]) r = 1'b1;
        end
        return r;
    endfunction

    function automatic logic floor_in_range(input int floor, input int num_floors);
        return floor < num_floors;
    endfunction

    function automatic int floor_dist(input int a, input int b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lift_car.sv
`default_nettype none
// ============================================================================
//  Module      : lift_car
//  Description : One lift car: pending-stop bitmap, SCAN direction logic,
//                move/door timers and emergency-stop freeze.
//  Ports       : clk, i_rst_n (async, active-low)
//                i_set_mask  - floors to add to the bitmap this edge
//                i_estop     - emergency stop level
//                o_floor / o_door / o_dir / o_requests - car status
//  Revision    : 1.0  initial release
// ============================================================================
module lift_car
    import lift_pkg::*;
#(
    parameter int NUM_FLOORS  = 8,
    parameter int MOVE_CYCLES = 2,
    parameter int DOOR_CYCLES = 3,
    parameter int FW          = $clog2(NUM_FLOORS)
) (
    input  logic                  clk,
    input  logic                  i_rst_n,
    input  logic [NUM_FLOORS-1:0] i_set_mask,
    input  logic                  i_estop,
    output logic [FW-1:0]         o_floor,
    output door_t                 o_door,
    output dir_t                  o_dir,
    output logic [NUM_FLOORS-1:0] o_requests
);

    localparam int c_TMAX = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
    localparam int c_TW   = $clog2(c_TMAX + 1);
    localparam logic [c_TW-1:0] c_MOVE_LAST = c_TW'(MOVE_CYCLES - 1);
    localparam logic [c_TW-1:0] c_DOOR_LAST = c_TW'(DOOR_CYCLES - 1);
    localparam logic [FW-1:0]   c_TOP       = FW'(NUM_FLOORS - 1);

    car_state_t             r_state, w_state_nxt;
    car_state_t             r_saved, w_saved_nxt;   // state frozen by e-stop
    logic [FW-1:0]          r_floor, w_floor_nxt;
    dir_t                   r_dir,   w_dir_nxt;
    logic [c_TW-1:0]        r_timer, w_timer_nxt;
    logic [NUM_FLOORS-1:0]  r_req,   w_req_nxt;

    logic [NUM_FLOORS-1:0]   w_pend, w_here, w_step_hot;
    logic [FW-1:0]           w_step;
    logic                    w_at_end;
    logic [c_MAX_FLOORS-1:0] w_rest64;
    logic                    w_rest_up, w_rest_dn;
    logic                    w_has_up, w_has_dn;
    int                      w_d_up, w_d_dn;

    // Requests arriving this edge are always stored, whatever the state.
    assign w_pend   = r_req | i_set_mask;
    assign w_step   = (r_dir == DIR_UP) ? (r_floor + 1'b1) : (r_floor - 1'b1);
    assign w_at_end = (r_dir == DIR_IDLE) ||
                      (r_dir == DIR_UP   && r_floor == c_TOP) ||
                      (r_dir == DIR_DOWN && r_floor == '0);

    always_comb begin
        w_here              = '0;
        w_here[r_floor]     = 1'b1;
        w_step_hot          = '0;
        w_step_hot[w_step]  = 1'b1;
        w_rest64            = '0;
        w_rest64[NUM_FLOORS-1:0] = w_pend & ~w_here;
    end

    assign w_rest_up = any_above(w_rest64, int'(r_floor));
    assign w_rest_dn = any_below(w_rest64, int'(r_floor));

    // Nearest pending stop on each side, for the departure direction from
    // rest. Ascending scan: first hit above and last hit below are nearest.
    always_comb begin
        w_has_up = 1'b0;
        w_has_dn = 1'b0;
        w_d_up   = 0;
        w_d_dn   = 0;
        for (int f = 0; f < NUM_FLOORS; f++) begin
            if (r_req[f]) begin
                if (f > int'(r_floor) && !w_has_up) begin
                    w_has_up = 1'b1;
                    w_d_up   = f - int'(r_floor);
                end
                if (f < int'(r_floor)) begin
                    w_has_dn = 1'b1;
                    w_d_dn   = int'(r_floor) - f;
                end
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_saved <= ST_IDLE;
            r_floor <= '0;
            r_dir   <= DIR_IDLE;
            r_timer <= '0;
            r_req   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_saved <= w_saved_nxt;
            r_floor <= w_floor_nxt;
            r_dir   <= w_dir_nxt;
            r_timer <= w_timer_nxt;
            r_req   <= w_req_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_saved_nxt = r_saved;
        w_floor_nxt = r_floor;
        w_dir_nxt   = r_dir;
        w_timer_nxt = r_timer;
        w_req_nxt   = w_pend;

        if (r_state == ST_ESTOP) begin
            // Timers and position stay frozen; resume exactly where we were.
            if (!i_estop) w_state_nxt = r_saved;
        end else if (i_estop) begin
            w_state_nxt = ST_ESTOP;
            w_saved_nxt = r_state;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_req[r_floor]) begin
                        w_state_nxt = ST_DOOR;
                        w_timer_nxt = '0;
                        w_req_nxt   = w_pend & ~w_here;
                    end else if (w_has_up || w_has_dn) begin
                        w_state_nxt = ST_MOVING;
                        w_timer_nxt = '0;
                        // Equal distance on both sides departs upward.
                        w_dir_nxt   = (w_has_up && (!w_has_dn || w_d_up <= w_d_dn))
                                      ? DIR_UP : DIR_DOWN;
                    end else begin
                        w_dir_nxt   = DIR_IDLE;
                    end
                end
                ST_MOVING: begin
                    if (r_timer != c_MOVE_LAST) begin
                        w_timer_nxt = r_timer + 1'b1;
                    end else if (w_at_end) begin
                        // Nothing can lie beyond the shaft ends; park safely.
                        w_state_nxt = ST_IDLE;
                        w_dir_nxt   = DIR_IDLE;
                        w_timer_nxt = '0;
                    end else begin
                        w_floor_nxt = w_step;
                        w_timer_nxt = '0;
                        if (w_pend[w_step]) begin
                            w_state_nxt = ST_DOOR;
                            w_req_nxt   = w_pend & ~w_step_hot;
                        end
                    end
                end
                ST_DOOR: begin
                    w_req_nxt = w_pend & ~w_here;
                    if (w_pend[r_floor]) begin
                        // Fresh call for this landing keeps the door open.
                        w_timer_nxt = '0;
                    end else if (r_timer != c_DOOR_LAST) begin
                        w_timer_nxt = r_timer + 1'b1;
                    end else begin
                        w_timer_nxt = '0;
                        if ((r_dir == DIR_UP && w_rest_up) ||
                            (r_dir == DIR_DOWN && w_rest_dn)) begin
                            w_state_nxt = ST_MOVING;
                        end else if (r_dir == DIR_UP && w_rest_dn) begin
                            w_state_nxt = ST_MOVING;
                            w_dir_nxt   = DIR_DOWN;
                        end else if (r_dir == DIR_DOWN && w_rest_up) begin
                            w_state_nxt = ST_MOVING;
                            w_dir_nxt   = DIR_UP;
                        end else begin
                            w_state_nxt = ST_IDLE;
                            w_dir_nxt   = DIR_IDLE;
                        end
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Output logic: door is a pure function of state and frozen state.
    always_comb begin
        o_door = DOOR_CLOSED;
        case (r_state)
            ST_DOOR:  o_door = DOOR_OPEN;
            ST_ESTOP: o_door = (r_saved == ST_MOVING) ? DOOR_CLOSED : DOOR_HELD;
            default:  o_door = DOOR_CLOSED;
        endcase
    end

    assign o_floor    = r_floor;
    assign o_dir      = r_dir;
    assign o_requests = r_req;

endmodule
`default_nettype wire

// File: rtl/multi_lift_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : multi_lift_ctrl
//  Description : N-car lift controller. Nearest-car hall-call dispatcher with
//                valid/ready handshake feeding per-car SCAN controllers.
//  Ports       : clk, reset (async, active-low)
//                hall_valid/hall_floor/hall_ready - shared hall call
//                car_call_valid/car_call_floor    - per-car cab calls
//                emergency_stop, full_capacity    - per-car levels
//                current_floor, door, direction, requests - packed status
//  Revision    : 1.0  initial release
// ============================================================================
module multi_lift_ctrl
    import lift_pkg::*;
#(
    parameter int NUM_CARS    = 2,
    parameter int NUM_FLOORS  = 8,
    parameter int MOVE_CYCLES = 2,
    parameter int DOOR_CYCLES = 3,
    parameter int FW          = $clog2(NUM_FLOORS)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           hall_valid,
    input  logic [FW-1:0]                  hall_floor,
    output logic                           hall_ready,
    input  logic [NUM_CARS-1:0]            car_call_valid,
    input  logic [NUM_CARS*FW-1:0]         car_call_floor,
    input  logic [NUM_CARS-1:0]            emergency_stop,
    input  logic [NUM_CARS-1:0]            full_capacity,
    output logic [NUM_CARS*FW-1:0]         current_floor,
    output logic [NUM_CARS*2-1:0]          door,
    output logic [NUM_CARS*2-1:0]          direction,
    output logic [NUM_CARS*NUM_FLOORS-1:0] requests
);

    logic [NUM_CARS-1:0]   w_eligible;
    logic [FW-1:0]         w_floor [NUM_CARS];
    logic [NUM_FLOORS-1:0] w_req   [NUM_CARS];
    door_t                 w_door  [NUM_CARS];
    dir_t                  w_dir   [NUM_CARS];
    logic [NUM_FLOORS-1:0] w_hall_hot;
    logic                  w_in_range, w_absorb, w_found, w_take;
    int                    w_win, w_best;

    assign w_eligible = ~emergency_stop & ~full_capacity;
    assign hall_ready = |w_eligible;
    assign w_in_range = floor_in_range(int'(hall_floor), NUM_FLOORS);

    always_comb begin
        w_hall_hot = '0;
        if (w_in_range) w_hall_hot[hall_floor] = 1'b1;
    end

    // Absorb check and nearest eligible car; strict '<' in ascending order
    // leaves ties with the lowest index.
    always_comb begin
        w_absorb = 1'b0;
        w_found  = 1'b0;
        w_win    = 0;
        w_best   = 0;
        for (int i = 0; i < NUM_CARS; i++) begin
            if (w_in_range && w_req[i][hall_floor]) w_absorb = 1'b1;
            if (w_eligible[i] &&
                (!w_found || floor_dist(int'(w_floor[i]), int'(hall_floor)) < w_best)) begin
                w_found = 1'b1;
                w_win   = i;
                w_best  = floor_dist(int'(w_floor[i]), int'(hall_floor));
            end
        end
    end

    // Out-of-range or already-pending calls still complete the handshake.
    assign w_take = hall_valid && hall_ready && w_in_range && !w_absorb;

    for (genvar i = 0; i < NUM_CARS; i++) begin : g_car
        logic [FW-1:0]         w_cc_floor;
        logic [NUM_FLOORS-1:0] w_cc_hot;
        logic [NUM_FLOORS-1:0] w_set;

        assign w_cc_floor = car_call_floor[i*FW +: FW];

        always_comb begin
            w_cc_hot = '0;
            if (car_call_valid[i] && floor_in_range(int'(w_cc_floor), NUM_FLOORS))
                w_cc_hot[w_cc_floor] = 1'b1;
        end

        assign w_set = w_cc_hot | ((w_take && (w_win == i)) ? w_hall_hot : '0);

        lift_car #(
            .NUM_FLOORS  (NUM_FLOORS),
            .MOVE_CYCLES (MOVE_CYCLES),
            .DOOR_CYCLES (DOOR_CYCLES),
            .FW          (FW)
        ) u_car (
            .clk        (clk),
            .i_rst_n    (reset),
            .i_set_mask (w_set),
            .i_estop    (emergency_stop[i]),
            .o_floor    (w_floor[i]),
            .o_door     (w_door[i]),
            .o_dir      (w_dir[i]),
            .o_requests (w_req[i])
        );

        assign current_floor[i*FW +: FW]                 = w_floor[i];
        assign door[i*2 +: 2]                            = w_door[i];
        assign direction[i*2 +: 2]                       = w_dir[i];
        assign requests[i*NUM_FLOORS +: NUM_FLOORS]      = w_req[i];
    end

endmodule
`default_nettype wire

// File: tb/tb_multi_lift_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multi_lift_ctrl
//  Description : Self-checking bench for multi_lift_ctrl with a behavioural
//                per-car model (countdowns and floor arrays).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_multi_lift_ctrl;

    localparam int NC = 2;
    localparam int NF = 8;
    localparam int FW = 3;
    localparam int MC = 2;
    localparam int DC = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              hall_valid;
    logic [FW-1:0]     hall_floor;
    logic              hall_ready;
    logic [NC-1:0]     car_call_valid;
    logic [NC*FW-1:0]  car_call_floor;
    logic [NC-1:0]     emergency_stop;
    logic [NC-1:0]     full_capacity;
    logic [NC*FW-1:0]  current_floor;
    logic [NC*2-1:0]   door;
    logic [NC*2-1:0]   direction;
    logic [NC*NF-1:0]  requests;

    always #5 clk = ~clk;

    multi_lift_ctrl #(
        .NUM_CARS(NC), .NUM_FLOORS(NF), .MOVE_CYCLES(MC), .DOOR_CYCLES(DC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .hall_valid     (hall_valid),
        .hall_floor     (hall_floor),
        .hall_ready     (hall_ready),
        .car_call_valid (car_call_valid),
        .car_call_floor (car_call_floor),
        .emergency_stop (emergency_stop),
        .full_capacity  (full_capacity),
        .current_floor  (current_floor),
        .door           (door),
        .direction      (direction),
        .requests       (requests)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: floor, travel sign, cycles left to next floor (0 = not moving),
    // door cycles left (0 = closed), stopped flag, pending floors.
    int m_flr [NC];
    int m_dir [NC];
    int m_mv  [NC];
    int m_dr  [NC];
    bit m_stp [NC];
    bit m_req [NC][NF];

    function automatic void model_reset();
        for (int c = 0; c < NC; c++) begin
            m_flr[c] = 0; m_dir[c] = 0; m_mv[c] = 0; m_dr[c] = 0; m_stp[c] = 0;
            for (int f = 0; f < NF; f++) m_req[c][f] = 0;
        end
    endfunction

    function automatic bit m_ready();
        bit r = 0;
        for (int c = 0; c < NC; c++) if (!emergency_stop[c] && !full_capacity[c]) r = 1;
        return r;
    endfunction

    task automatic model_step();
        bit s [NC][NF];
        bit pend [NF];
        bit old [NF];
        bit absorbed, ahead, behind;
        int win, best, d, hf, f, bu, bd;
        for (int c = 0; c < NC; c++) for (int k = 0; k < NF; k++) s[c][k] = 0;
        hf = int'(hall_floor);
        if (hall_valid && m_ready() && hf < NF) begin
            absorbed = 0;
            for (int c = 0; c < NC; c++) if (m_req[c][hf]) absorbed = 1;
            if (!absorbed) begin
                win = -1; best = 0;
                for (int c = 0; c < NC; c++) begin
                    if (!emergency_stop[c] && !full_capacity[c]) begin
                        d = (m_flr[c] > hf) ? m_flr[c] - hf : hf - m_flr[c];
                        if (win < 0 || d < best) begin win = c; best = d; end
                    end
                end
                s[win][hf] = 1;
            end
        end
        for (int c = 0; c < NC; c++) begin
            f = int'(car_call_floor[c*FW +: FW]);
            if (car_call_valid[c] && f < NF) s[c][f] = 1;
        end
        for (int c = 0; c < NC; c++) begin
            for (int k = 0; k < NF; k++) begin
                old[k]  = m_req[c][k];
                pend[k] = old[k] | s[c][k];
            end
            if (m_stp[c]) begin
                if (!emergency_stop[c]) m_stp[c] = 0;
            end else if (emergency_stop[c]) begin
                m_stp[c] = 1;
            end else if (m_mv[c] > 0) begin
                m_mv[c]--;
                if (m_mv[c] == 0) begin
                    m_flr[c] += m_dir[c];
                    if (pend[m_flr[c]]) begin pend[m_flr[c]] = 0; m_dr[c] = DC; end
                    else m_mv[c] = MC;
                end
            end else if (m_dr[c] > 0) begin
                if (pend[m_flr[c]]) begin
                    pend[m_flr[c]] = 0; m_dr[c] = DC;
                end else begin
                    m_dr[c]--;
                    if (m_dr[c] == 0) begin
                        ahead = 0; behind = 0;
                        for (int k = 0; k < NF; k++) begin
                            if (pend[k] && (k - m_flr[c]) * m_dir[c] > 0) ahead = 1;
                            if (pend[k] && (k - m_flr[c]) * m_dir[c] < 0) behind = 1;
                        end
                        if (ahead) m_mv[c] = MC;
                        else if (behind) begin m_dir[c] = -m_dir[c]; m_mv[c] = MC; end
                        else m_dir[c] = 0;
                    end
                end
            end else begin
                if (old[m_flr[c]]) begin
                    pend[m_flr[c]] = 0; m_dr[c] = DC;
                end else begin
                    bu = NF + 1; bd = NF + 1;
                    for (int k = 0; k < NF; k++) begin
                        if (old[k] && k > m_flr[c] && k - m_flr[c] < bu) bu = k - m_flr[c];
                        if (old[k] && k < m_flr[c] && m_flr[c] - k < bd) bd = m_flr[c] - k;
                    end
                    if (bu <= NF || bd <= NF) begin
                        m_dir[c] = (bu <= bd) ? 1 : -1; m_mv[c] = MC;
                    end else m_dir[c] = 0;
                end
            end
            for (int k = 0; k < NF; k++) m_req[c][k] = pend[k];
        end
    endtask

    function automatic logic [63:0] exp_floor();
        logic [63:0] r = '0;
        for (int c = 0; c < NC; c++) r[c*FW +: FW] = FW'(m_flr[c]);
        return r;
    endfunction

    function automatic logic [63:0] exp_door();
        logic [63:0] r = '0;
        for (int c = 0; c < NC; c++)
            r[c*2 +: 2] = m_stp[c] ? ((m_mv[c] > 0) ? 2'b00 : 2'b10)
                                   : ((m_dr[c] > 0) ? 2'b01 : 2'b00);
        return r;
    endfunction

    function automatic logic [63:0] exp_dir();
        logic [63:0] r = '0;
        for (int c = 0; c < NC; c++)
            r[c*2 +: 2] = (m_dir[c] > 0) ? 2'b01 : (m_dir[c] < 0) ? 2'b10 : 2'b00;
        return r;
    endfunction

    function automatic logic [63:0] exp_req();
        logic [63:0] r = '0;
        for (int c = 0; c < NC; c++) for (int k = 0; k < NF; k++) r[c*NF + k] = m_req[c][k];
        return r;
    endfunction

    // Called at a negedge with inputs already driven; returns at next negedge.
    task automatic cycle();
        #1;
        check("hall_ready", hall_ready, m_ready());
        @(posedge clk);
        model_step();
        #1;
        check("current_floor", current_floor, exp_floor());
        check("door", door, exp_door());
        check("direction", direction, exp_dir());
        check("requests", requests, exp_req());
        @(negedge clk);
    endtask

    task automatic drive_quiet();
        hall_valid = 0; hall_floor = '0;
        car_call_valid = '0; car_call_floor = '0;
        emergency_stop = '0; full_capacity = '0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_floor"}, current_floor, 0);
        check({tag, "_door"}, door, 0);
        check({tag, "_dir"}, direction, 0);
        check({tag, "_req"}, requests, 0);
        check({tag, "_ready"}, hall_ready, 1);
    endtask

    initial begin
        reset = 1'b0;
        drive_quiet();
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_values("rst");
        reset = 1'b1;

        // Single hall call to floor 3: nearest tie goes to car 0.
        hall_valid = 1; hall_floor = 3'd3;
        cycle();
        hall_valid = 0;
        check("hall3_req", requests, 64'h0008);
        repeat (12) cycle();
        check("hall3_floor", current_floor[FW-1:0], 3);
        check("hall3_dir", direction, 0);
        check("hall3_req_clr", requests, 0);

        // Both cars stopped: hall call waits until car 1 is released.
        emergency_stop = 2'b11;
        cycle();
        hall_valid = 1; hall_floor = 3'd5;
        repeat (3) cycle();
        emergency_stop = 2'b01;
        cycle();
        hall_valid = 0;
        check("estop_hall_car1", requests[2*NF-1:NF], 8'h20);
        emergency_stop = 2'b00;
        repeat (20) cycle();

        // Full car 0 is skipped by the dispatcher.
        full_capacity = 2'b01; hall_valid = 1; hall_floor = 3'd6;
        cycle();
        drive_quiet();
        repeat (25) cycle();

        // Randomised traffic.
        for (int n = 0; n < 3000; n++) begin
            hall_valid = ($urandom_range(0, 2) == 0);
            hall_floor = FW'($urandom_range(0, NF - 1));
            for (int c = 0; c < NC; c++) begin
                car_call_valid[c] = ($urandom_range(0, 7) == 0);
                car_call_floor[c*FW +: FW] = FW'($urandom_range(0, NF - 1));
                if (emergency_stop[c]) emergency_stop[c] = ($urandom_range(0, 3) != 0);
                else emergency_stop[c] = ($urandom_range(0, 39) == 0);
                if ($urandom_range(0, 11) == 0) full_capacity[c] = ~full_capacity[c];
            end
            cycle();
        end

        // Asynchronous reset in the middle of a trip.
        drive_quiet();
        repeat (30) cycle();
        hall_valid = 1; hall_floor = 3'd7;
        cycle();
        hall_valid = 0;
        repeat (3) cycle();
        #2 reset = 1'b0;
        #1 check_reset_values("midrst");
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        car_call_valid = 2'b10; car_call_floor = 6'b010_000;
        cycle();
        car_call_valid = '0;
        repeat (15) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
